// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic path (BCD adder/subtractor).
//   DIGIT_W       : width of one 8-4-2-1 BCD digit
//   BCD_MAX       : largest legal digit value
//   state_e       : serial subtractor FSM states
//   is_bcd_digit(): 1 when a 4-bit code is a legal BCD digit
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle of the serial BCD subtractor.
//   master: drives start, a, b; observes busy, done, diff, neg, invalid
//   slave : the subtractor side
interface bcd_serial_subtractor_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = DIGITS * DIGIT_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         invalid;

    modport master (
        output start, a, b,
        input  busy, done, diff, neg, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, neg, invalid
    );

endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract: {bout, d} = x - y - bin,
// with a negative raw difference corrected by +10 and a borrow out.
//   x_i, y_i : BCD digits (y_i <= 9)
//   bin_i    : borrow in
//   d_o      : BCD result digit
//   bout_o   : borrow out
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x_i,
    input  logic [DIGIT_W-1:0] y_i,
    input  logic               bin_i,
    output logic [DIGIT_W-1:0] d_o,
    output logic               bout_o
);
    localparam int unsigned TW = DIGIT_W + 1;

    logic [TW-1:0] raw;

    // Range is -10..9, so the top bit of the 5-bit result is the sign.
    always_comb begin
        raw    = TW'(x_i) - TW'(y_i) - TW'(bin_i);
        bout_o = raw[TW-1];
        d_o    = raw[TW-1] ? DIGIT_W'(raw + TW'(BCD_MAX + 1)) : DIGIT_W'(raw);
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD |a - b|, least-significant digit first, one digit per clock.
// A negative raw result is turned into its magnitude by a ten's-complement pass.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_serial_subtractor_if (start/a/b in,
//           busy/done/diff/neg/invalid out, all registered)
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_serial_subtractor_if.slave   bus
);
    localparam int unsigned W     = DIGITS * DIGIT_W;
    localparam int unsigned IDX_W = $clog2(DIGITS) + 1;

    state_e              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        res_q, res_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                brw_q, brw_d;
    logic                neg_q, neg_d;
    logic                inv_q, inv_d;
    logic                pend_q, pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                ops_ok;
    logic                last;
    logic [DIGIT_W-1:0]  sub_x, sub_y, sub_d;
    logic                sub_bout;

    // Validity of the operands presented at the request.
    always_comb begin
        ops_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bus.a[i*DIGIT_W +: DIGIT_W]) ||
                !is_bcd_digit(bus.b[i*DIGIT_W +: DIGIT_W]))
                ops_ok = 1'b0;
        end
    end

    // One digit slice shared by both passes: a_i - b_i in SUB, 0 - raw_i in NEG.
    assign sub_x = (state_q == NEG) ? '0 : a_q[DIGIT_W-1:0];
    assign sub_y = (state_q == NEG) ? res_q[DIGIT_W-1:0] : b_q[DIGIT_W-1:0];
    assign last  = (idx_q == IDX_W'(DIGITS - 1));

    bcd_digit_sub u_digit (
        .x_i    (sub_x),
        .y_i    (sub_y),
        .bin_i  (brw_q),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            neg_q   <= 1'b0;
            inv_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            neg_q   <= neg_d;
            inv_q   <= inv_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and datapath. The result register shifts right each step with
    // the new digit entering at the MSD, so after DIGITS steps it is aligned and
    // its LSD is the next raw digit the NEG pass consumes.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        neg_d   = neg_q;
        inv_d   = inv_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Rejected request: one cycle after acceptance, report it.
                    pend_d  = 1'b0;
                    state_d = DONE;
                end else if (bus.start) begin
                    a_d    = bus.a;
                    b_d    = bus.b;
                    res_d  = '0;
                    idx_d  = '0;
                    brw_d  = 1'b0;
                    neg_d  = 1'b0;
                    inv_d  = !ops_ok;
                    if (ops_ok) state_d = SUB;
                    else        pend_d  = 1'b1;
                end
            end
            SUB: begin
                res_d = (res_q >> DIGIT_W) | (W'(sub_d) << (W - DIGIT_W));
                a_d   = a_q >> DIGIT_W;
                b_d   = b_q >> DIGIT_W;
                brw_d = sub_bout;
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d = '0;
                    if (sub_bout) begin
                        state_d = NEG;
                        neg_d   = 1'b1;
                        brw_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            NEG: begin
                res_d = (res_q >> DIGIT_W) | (W'(sub_d) << (W - DIGIT_W));
                brw_d = sub_bout;
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d   = '0;
                    brw_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SUB) || (state_d == NEG);
        done_d = (state_d == DONE);
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.diff    = res_q;
    assign bus.neg     = neg_q;
    assign bus.invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4) with an integer-level
// reference model of |a - b|, sign, validity and latency.
module tb_bcd_serial_subtractor;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = DIGITS * 4;

    logic clk;
    logic rst_n;

    bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expectations armed by the driver, consumed by the monitor on done.
    logic         armed = 1'b0;
    logic [W-1:0] exp_diff;
    logic         exp_neg;
    logic         exp_inv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on decoded operands.
    function automatic bit all_digits_ok(input logic [W-1:0] v);
        logic [3:0] d;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[i*4 +: 4];
            if (d > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic n, output logic inv,
                         output int lat, output int busy_cycles);
        int ia, ib;
        if (!all_digits_ok(a) || !all_digits_ok(b)) begin
            d = '0; n = 1'b0; inv = 1'b1; lat = 2; busy_cycles = 0;
            return;
        end
        ia  = bcd_to_int(a);
        ib  = bcd_to_int(b);
        inv = 1'b0;
        n   = (ia < ib);
        d   = int_to_bcd(n ? ib - ia : ia - ib);
        lat = n ? 2 * DIGITS + 1 : DIGITS + 1;
        busy_cycles = lat - 1;
    endtask

    // Monitor: output consistency every cycle, results whenever done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy && bus.done) chk("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) begin
                if (!armed) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    chk("diff", 32'(bus.diff), 32'(exp_diff));
                    chk("neg", 32'(bus.neg), 32'(exp_neg));
                    chk("invalid", 32'(bus.invalid), 32'(exp_inv));
                end
            end
        end
    end

    // Issue one request; optionally pulse a competing start at cycle ign_at.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_at);
        int lat_exp, busy_exp, lat, nbusy;
        bit seen;
        model(a, b, exp_diff, exp_neg, exp_inv, lat_exp, busy_exp);
        armed = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        lat = 0; nbusy = 0; seen = 1'b0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            bus.a     = 16'h1234;
            bus.b     = 16'h5678;
            if (ign_at != 0 && lat == ign_at) bus.start = 1'b1;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("busy_cycles", 32'(nbusy), 32'(busy_exp));
        #1 armed = 1'b0;
        // Results hold after the done pulse.
        @(negedge clk);
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("diff_hold", 32'(bus.diff), 32'(exp_diff));
        chk("neg_hold", 32'(bus.neg), 32'(exp_neg));
    endtask

    initial begin
        logic [W-1:0] md;
        logic mn, mi;
        int ml, mb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_neg", 32'(bus.neg), 32'd0);
        chk("rst_invalid", 32'(bus.invalid), 32'd0);
        rst_n = 1'b1;

        // Pin the model with hand-computed answers.
        model(16'h0053, 16'h0027, md, mn, mi, ml, mb);
        chk("model_53_27", {15'd0, mn, md}, 32'h0000_0026);
        chk("model_lat_pos", 32'(ml), 32'd5);
        model(16'h0027, 16'h0053, md, mn, mi, ml, mb);
        chk("model_27_53", {15'd0, mn, md}, 32'h0001_0026);
        chk("model_lat_neg", 32'(ml), 32'd9);
        model(16'h1000, 16'h0001, md, mn, mi, ml, mb);
        chk("model_1000_1", 32'(md), 32'h0999);
        model(16'h00A3, 16'h0001, md, mn, mi, ml, mb);
        chk("model_invalid", {31'd0, mi}, 32'd1);

        // Directed vectors.
        run_op(16'h0053, 16'h0027, 0);
        run_op(16'h0027, 16'h0053, 0);
        run_op(16'h1000, 16'h0001, 0);
        run_op(16'h0000, 16'h9999, 0);
        run_op(16'h4321, 16'h4321, 0);
        run_op(16'h00A3, 16'h0001, 0);
        chk("invalid_diff_zero", 32'(bus.diff), 32'd0);
        run_op(16'h9999, 16'h0000, 0);
        run_op(16'h0001, 16'h0002, 0);

        // Start pulses while busy are ignored.
        run_op(16'h0053, 16'h0027, 2);
        run_op(16'h0027, 16'h0053, 6);

        // Reset at the second SUB edge aborts with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0053;
        bus.b     = 16'h0027;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_before_abort", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_neg", 32'(bus.neg), 32'd0);
        chk("abort_invalid", 32'(bus.invalid), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle", 32'(bus.busy), 32'd0);

        // Subtractor is usable again after the abort.
        run_op(16'h0500, 16'h0250, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
